// File: rtl/count8_arbctrl_if.sv
// Requester and counter-side signals of the shared 8-bit counter arbiter.
// The arbiter uses the slave modport; requesters and the counter use master.
interface count8_arbctrl_if #(parameter int WIDTH = 8);
  logic             req0;
  logic [WIDTH-1:0] start0;
  logic [WIDTH-1:0] term0;
  logic             req1;
  logic [WIDTH-1:0] start1;
  logic [WIDTH-1:0] term1;
  logic             abort;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_load;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_val;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;

  modport slave (
    input  req0, start0, term0, req1, start1, term1, abort, cnt_q,
    output cnt_load, cnt_en, cnt_val, gnt0, gnt1, done0, done1, busy
  );

  modport master (
    output req0, start0, term0, req1, start1, term1, abort, cnt_q,
    input  cnt_load, cnt_en, cnt_val, gnt0, gnt1, done0, done1, busy
  );
endinterface

// File: rtl/count8_arbctrl.sv
// Two-way round-robin controller for a shared loadable up-counter.
// A granted job loads its start value, counts until cnt_q hits its terminal
// value, pulses done to the owner and releases the counter.
module count8_arbctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               res,
  count8_arbctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] term;
  } job_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   ptr_q, ptr_d;     // index of the requester favoured on a tie
  job_t   job_q, job_d;
  logic   sel;
  logic   match;

  // Tie goes to the pointer; a lone request wins outright.
  assign sel   = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
  assign match = (bus.cnt_q == job_q.term);

  // State, owner, pointer and latched job operands.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      job_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      job_q   <= job_d;
    end
  end

  // Next-state: abort in LOAD/RUN beats a terminal match and still rotates.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    job_d   = job_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = sel;
          job_d   = sel ? job_t'{start: bus.start1, term: bus.term1}
                        : job_t'{start: bus.start0, term: bus.term0};
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end else if (match) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore decode of grant/done/load; enable also looks at cnt_q and abort.
  always_comb begin
    bus.busy     = (state_q != IDLE);
    bus.gnt0     = bus.busy && !owner_q;
    bus.gnt1     = bus.busy &&  owner_q;
    bus.done0    = (state_q == DONE) && !owner_q;
    bus.done1    = (state_q == DONE) &&  owner_q;
    bus.cnt_load = (state_q == LOAD);
    bus.cnt_val  = job_q.start;
    bus.cnt_en   = (state_q == RUN) && !bus.abort && !match;
  end

endmodule

// File: tb/tb_count8_arbctrl.sv
// Directed bench for count8_arbctrl with a behavioural load/enable counter.
module tb_count8_arbctrl;
  logic clk = 1'b0;
  logic res = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] cnt = 8'd0;

  count8_arbctrl_if #(.WIDTH(8)) bus ();

  count8_arbctrl #(.WIDTH(8)) dut (.clk(clk), .res(res), .bus(bus));

  always #5 clk = ~clk;

  // Shared counter: load has priority over enable, never reset by the controller.
  always @(posedge clk) begin
    if (bus.cnt_load)    cnt <= bus.cnt_val;
    else if (bus.cnt_en) cnt <= cnt + 8'd1;
  end
  assign bus.cnt_q = cnt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, then sample 1ns after the edge; grants/dones stay exclusive.
  task automatic step();
    @(posedge clk);
    #1;
    chk("gnt_excl", {7'd0, bus.gnt0 & bus.gnt1}, 8'd0);
    chk("done_excl", {7'd0, bus.done0 & bus.done1}, 8'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
    chk({tag, "_gnt"}, {6'd0, bus.gnt1, bus.gnt0}, 8'd0);
    chk({tag, "_done"}, {6'd0, bus.done1, bus.done0}, 8'd0);
    chk({tag, "_ld_en"}, {6'd0, bus.cnt_load, bus.cnt_en}, 8'd0);
  endtask

  // Entered in the LOAD cycle of a job owned by 'who'; ends in the following IDLE cycle.
  task automatic job(input bit who, input logic [7:0] s, input logic [7:0] t);
    logic [7:0] n;
    logic [7:0] e;
    n = t - s;
    chk("load_gnt", {6'd0, bus.gnt1, bus.gnt0}, who ? 8'd2 : 8'd1);
    chk("load_pulse", {7'd0, bus.cnt_load}, 8'd1);
    chk("load_en", {7'd0, bus.cnt_en}, 8'd0);
    chk("load_val", bus.cnt_val, s);
    chk("load_busy", {7'd0, bus.busy}, 8'd1);
    if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    step();
    e = s;
    for (int k = 0; k < int'(n); k++) begin
      chk("run_en", {7'd0, bus.cnt_en}, 8'd1);
      chk("run_cnt", bus.cnt_q, e);
      chk("run_ld", {7'd0, bus.cnt_load}, 8'd0);
      e = e + 8'd1;
      step();
    end
    chk("match_en", {7'd0, bus.cnt_en}, 8'd0);
    chk("match_cnt", bus.cnt_q, t);
    chk("match_done", {6'd0, bus.done1, bus.done0}, 8'd0);
    step();
    chk("done_pulse", {6'd0, bus.done1, bus.done0}, who ? 8'd2 : 8'd1);
    chk("done_gnt", {6'd0, bus.gnt1, bus.gnt0}, who ? 8'd2 : 8'd1);
    step();
    chk_idle("after_done");
  endtask

  initial begin
    bus.req0 = 1'b0; bus.start0 = 8'd0; bus.term0 = 8'd0;
    bus.req1 = 1'b0; bus.start1 = 8'd0; bus.term1 = 8'd0;
    bus.abort = 1'b0;

    // Reset state.
    #12;
    chk_idle("reset");
    chk("reset_val", bus.cnt_val, 8'd0);
    @(negedge clk); res = 1'b1;

    // Single job: 3 -> 7, four enable cycles.
    bus.req0 = 1'b1; bus.start0 = 8'd3; bus.term0 = 8'd7;
    step();
    job(1'b0, 8'd3, 8'd7);

    // Both requesting out of reset: 0 then 1, then alternation on re-request.
    res = 1'b0;
    bus.req0 = 1'b1; bus.start0 = 8'd0; bus.term0 = 8'd2;
    bus.req1 = 1'b1; bus.start1 = 8'd0; bus.term1 = 8'd2;
    #2;
    chk_idle("reset2");
    @(negedge clk); res = 1'b1;
    step();
    job(1'b0, 8'd0, 8'd2);
    step();
    job(1'b1, 8'd0, 8'd2);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    job(1'b0, 8'd0, 8'd2);
    step();
    job(1'b1, 8'd0, 8'd2);

    // Wrap-around 250 -> 4: ten enable cycles through 255 -> 0.
    bus.req1 = 1'b1; bus.start1 = 8'd250; bus.term1 = 8'd4;
    step();
    job(1'b1, 8'd250, 8'd4);

    // start == term: no enable cycles, done two cycles after the load.
    bus.req0 = 1'b1; bus.start0 = 8'd9; bus.term0 = 8'd9;
    step();
    job(1'b0, 8'd9, 8'd9);

    // Abort on the second RUN cycle; pending req1 is served next.
    bus.req0 = 1'b1; bus.start0 = 8'd0; bus.term0 = 8'd100;
    step();
    chk("ab_gnt", {6'd0, bus.gnt1, bus.gnt0}, 8'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.start1 = 8'd5; bus.term1 = 8'd6;
    step();
    chk("ab_run1_en", {7'd0, bus.cnt_en}, 8'd1);
    step();
    chk("ab_run2_cnt", bus.cnt_q, 8'd1);
    bus.abort = 1'b1;
    #1;
    chk("ab_en_drop", {7'd0, bus.cnt_en}, 8'd0);
    chk("ab_no_done", {6'd0, bus.done1, bus.done0}, 8'd0);
    step();
    bus.abort = 1'b0;
    chk_idle("ab_idle");
    chk("ab_cnt_hold", bus.cnt_q, 8'd1);
    step();
    job(1'b1, 8'd5, 8'd6);

    // Asynchronous reset mid-RUN, then the still-pending req1 is granted.
    bus.req1 = 1'b1; bus.start1 = 8'd10; bus.term1 = 8'd50;
    step();
    step();
    step();
    chk("rst_run_cnt", bus.cnt_q, 8'd11);
    #2;
    res = 1'b0;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid_val", bus.cnt_val, 8'd0);
    @(negedge clk); res = 1'b1;
    step();
    chk("rst_cnt_kept", bus.cnt_q, 8'd11);
    job(1'b1, 8'd10, 8'd50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/count8_arbctrl.md
Name: count8_arbctrl

Overview:
- Controller and two-way round-robin arbiter for the shared 8-bit loadable up-counter (load/enable counter with CNT_In load path).
- Grants the counter to one of two requesters at a time.
- Loads the requester's start value, enables counting until the counter output equals the requester's terminal value, then pulses done to that requester and releases the counter.
- Sits between the requester blocks and the counter; it never resets the counter itself.

Parameters:
- WIDTH, 8, counter/operand width; must match the counter (only 8 supported).

Ports:
- clk  input  1  rising-edge clock
- res  input  1  asynchronous active-low reset
- req0  input  1  requester 0 job request; held high until gnt0
- start0  input  WIDTH  requester 0 start value; sampled with grant
- term0  input  WIDTH  requester 0 terminal value; sampled with grant
- req1  input  1  requester 1 job request
- start1  input  WIDTH  requester 1 start value
- term1  input  WIDTH  requester 1 terminal value
- abort  input  1  cancel the current job
- cnt_q  input  WIDTH  counter output (CNT)
- cnt_load  output  1  to counter load
- cnt_en  output  1  to counter EN
- cnt_val  output  WIDTH  to counter CNT_In
- gnt0  output  1  requester 0 owns the counter
- gnt1  output  1  requester 1 owns the counter
- done0  output  1  one-cycle completion pulse to requester 0
- done1  output  1  one-cycle completion pulse to requester 1
- busy  output  1  state != IDLE

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE; RR pointer=0 (requester 0 favoured).
  - start_reg=term_reg=0, owner=0.
  - All outputs 0.
- States: IDLE, LOAD, RUN, DONE. State, owner, start_reg, term_reg and pointer are registered.
- Output decoding:
  - gnt/done/busy/cnt_load/cnt_val are Moore (state-decoded).
  - cnt_en is Mealy on cnt_q.
- IDLE:
  - Any req high → select owner. Only one request: that one. Both: the pointer-favoured one.
  - Latch that owner's start/term into start_reg/term_reg; next=LOAD.
- LOAD:
  - cnt_load=1, cnt_val=start_reg, cnt_en=0, gnt_owner=1; next=RUN.
  - cnt_val=start_reg in all states; cnt_load=0 outside LOAD.
- RUN:
  - gnt_owner=1.
  - cnt_q != term_reg → cnt_en=1, stay.
  - cnt_q == term_reg → cnt_en=0, next=DONE.
- DONE:
  - gnt_owner=1, done_owner=1 for exactly one cycle.
  - Pointer ← other requester; next=IDLE.
- Latency:
  - Request sampled in IDLE at cycle N → gnt and cnt_load high at N+1.
  - Counter holds start at N+2.
  - cnt_en high for exactly (term−start) mod 256 cycles.
  - done at N+3+((term−start) mod 256).
- Wrap-around: term < start counts through 255→0 (no special handling).
- start == term: zero enable cycles; RUN lasts one cycle, then DONE.
- Back-to-back jobs: at least one IDLE cycle between jobs. A request arriving during LOAD/RUN/DONE waits; the non-owner's req is never dropped, only deferred.
- The owner's req is ignored while granted. A re-asserted req after done is a new job.
- abort:
  - In LOAD or RUN: next=IDLE; cnt_en=0 that cycle; no done pulse; pointer still rotates to the other requester.
  - In IDLE or DONE: ignored; DONE completes normally.
  - Same cycle as the cnt_q==term_reg match: abort wins, no done.
- At most one of gnt0/gnt1 is high; at most one of done0/done1 is high.
- start/term inputs are don't-care except in the IDLE grant cycle.
- Reset mid-job: immediate return to IDLE with all outputs 0; the counter keeps its value.

Test Plan:
- Reset, then req0 with start0=3, term0=7 → gnt0 from N+1; cnt_load one cycle with cnt_val=3; cnt_en high 4 cycles (cnt_q 3→7); done0 single pulse at N+7; gnt0 low at N+8; busy low at N+8.
- req0 and req1 both high from reset, both jobs start=0, term=2 → requester 0 served first, then requester 1 after one IDLE cycle. Simultaneous re-request → requester 0 granted next (alternation); never both gnt.
- Wrap: start1=250, term1=4 → cnt_en high exactly 10 cycles; cnt_q passes 255→0; done1 once.
- start0=term0=9 → cnt_load then zero cnt_en cycles; done0 at N+3.
- abort asserted on the 2nd RUN cycle of start=0, term=100 → cnt_en drops that cycle, no done0, busy low next cycle. A pending req1 is granted next.
- res pulled low mid-RUN (asynchronous, between clock edges) → all outputs 0 immediately. After release, req1 pending → gnt1 (pointer reset favours requester 0 only if req0 is also high).
